// File: rtl/batch_sequencer.sv
// Batch sequencer between a host FIFO pair and a parallel kernel array:
// gathers one batch of elements, waits for every kernel result, streams results back.
module batch_sequencer #(
  parameter int DATA_W       = 16,
  parameter int WORD_W       = 32,
  parameter int ELEMS        = 512,
  parameter int EXEC_TIMEOUT = 65535
) (
  input  logic                    bus_clk,
  input  logic                    rst,
  input  logic                    host_open,
  input  logic                    recv_empty,
  input  logic [WORD_W-1:0]       recv_data,
  output logic                    recv_rden,
  input  logic                    send_full,
  output logic                    send_wren,
  output logic [WORD_W-1:0]       send_data,
  output logic [ELEMS*DATA_W-1:0] krn_in_data,
  output logic [ELEMS-1:0]        krn_in_valid,
  input  logic [ELEMS*DATA_W-1:0] krn_out_data,
  input  logic [ELEMS-1:0]        krn_out_valid,
  output logic [4:0]              state,
  output logic [15:0]             batch_count,
  output logic                    timeout_flag
);

  localparam int unsigned LANES = WORD_W / DATA_W;
  localparam int unsigned WORDS = ELEMS / LANES;
  localparam int CW = $clog2(WORDS) + 1;
  localparam int EW = (EXEC_TIMEOUT > 0) ? $clog2(EXEC_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_WORD  = CW'(WORDS - 1);
  localparam logic [EW-1:0] EXEC_LIMIT = EW'(EXEC_TIMEOUT);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_RECV = 5'b00010,
    S_EXEC = 5'b00100,
    S_SEND = 5'b01000,
    S_ERR  = 5'b10000
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           word_q;
  logic [EW-1:0]           exec_q;
  logic [ELEMS*DATA_W-1:0] in_data_q, in_data_d;
  logic [ELEMS-1:0]        in_valid_q, in_valid_d;
  logic [15:0]             batch_q;
  logic                    timeout_q;
  logic                    pop, push, exec_done;

  assign pop          = (state_q == S_RECV) && !recv_empty;
  assign push         = (state_q == S_SEND) && !send_full;
  assign exec_done    = &krn_out_valid;
  assign recv_rden    = pop;
  assign send_wren    = push;
  assign state        = state_q;
  assign krn_in_data  = in_data_q;
  assign krn_in_valid = in_valid_q;
  assign batch_count  = batch_q;
  assign timeout_flag = timeout_q;

  // A word's lanes are contiguous elements, so word w maps to bits [w*WORD_W +: WORD_W].
  always_comb begin
    in_data_d  = in_data_q;
    in_valid_d = in_valid_q;
    send_data  = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (word_q == CW'(w)) begin
        send_data = krn_out_data[w*WORD_W +: WORD_W];
        if (pop) begin
          in_data_d[w*WORD_W +: WORD_W] = recv_data;
          in_valid_d[w*LANES +: LANES]  = '1;
        end
      end
    end
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      exec_q     <= '0;
      in_data_q  <= '0;
      in_valid_q <= '0;
      batch_q    <= '0;
      timeout_q  <= 1'b0;
    end else if (!host_open) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      exec_q     <= '0;
      in_valid_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_RECV;
          word_q  <= '0;
        end
        S_RECV: begin
          if (pop) begin
            in_data_q  <= in_data_d;
            in_valid_q <= in_valid_d;
            if (word_q == LAST_WORD) begin
              state_q <= S_EXEC;
              word_q  <= '0;
              exec_q  <= '0;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        S_EXEC: begin
          // A result arriving on the limit cycle still wins over the abort.
          if (exec_done) begin
            state_q <= S_SEND;
            word_q  <= '0;
            exec_q  <= '0;
          end else if (exec_q == EXEC_LIMIT) begin
            state_q   <= S_ERR;
            word_q    <= '0;
            timeout_q <= 1'b1;
          end else begin
            exec_q <= exec_q + 1'b1;
          end
        end
        S_SEND: begin
          if (push) begin
            if (word_q == LAST_WORD) begin
              state_q    <= S_IDLE;
              word_q     <= '0;
              in_valid_q <= '0;
              batch_q    <= batch_q + 16'd1;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_IDLE;
          word_q  <= '0;
          exec_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_batch_sequencer.sv
// Directed bench for batch_sequencer with ELEMS=8, 16-bit elements, 32-bit words,
// a FIFO model on each side and a +1 kernel that answers 3 cycles after inputs are valid.
module tb_batch_sequencer;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_RECV = 5'b00010;
  localparam logic [4:0] ST_EXEC = 5'b00100;
  localparam logic [4:0] ST_SEND = 5'b01000;
  localparam logic [4:0] ST_ERR  = 5'b10000;

  logic         clk, rst, host_open, recv_empty, recv_rden, send_full, send_wren;
  logic [31:0]  recv_data, send_data;
  logic [127:0] krn_in_data, krn_out_data;
  logic [7:0]   krn_in_valid, krn_out_valid;
  logic [4:0]   state;
  logic [15:0]  batch_count;
  logic         timeout_flag;

  int errors = 0;
  int checks = 0;

  logic [31:0]  fifo_mem [0:255];
  int unsigned  fifo_rd = 0;
  int unsigned  fifo_wr = 0;
  logic         hold_empty = 1'b0;
  logic [31:0]  cap_mem [0:255];
  int unsigned  cap_n = 0;
  logic         kblock = 1'b0;
  int           kcnt;
  logic [127:0] in_snap;

  batch_sequencer #(
    .DATA_W(16),
    .WORD_W(32),
    .ELEMS(8),
    .EXEC_TIMEOUT(20)
  ) dut (
    .bus_clk(clk),
    .rst(rst),
    .host_open(host_open),
    .recv_empty(recv_empty),
    .recv_data(recv_data),
    .recv_rden(recv_rden),
    .send_full(send_full),
    .send_wren(send_wren),
    .send_data(send_data),
    .krn_in_data(krn_in_data),
    .krn_in_valid(krn_in_valid),
    .krn_out_data(krn_out_data),
    .krn_out_valid(krn_out_valid),
    .state(state),
    .batch_count(batch_count),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign recv_empty = hold_empty | (fifo_rd == fifo_wr);
  assign recv_data  = fifo_mem[fifo_rd[7:0]];

  always @(posedge clk) begin
    if (recv_rden) fifo_rd <= fifo_rd + 1;
    if (send_wren) begin
      cap_mem[cap_n[7:0]] <= send_data;
      cap_n <= cap_n + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      kcnt <= 0;
      krn_out_valid <= '0;
      krn_out_data <= '0;
    end else if (&krn_in_valid) begin
      if (kcnt < 3) kcnt <= kcnt + 1;
      else begin
        krn_out_valid <= kblock ? 8'h7F : 8'hFF;
        for (int i = 0; i < 8; i++)
          krn_out_data[i*16 +: 16] <= krn_in_data[i*16 +: 16] + 16'd1;
      end
    end else begin
      kcnt <= 0;
      krn_out_valid <= '0;
    end
  end

  task automatic load_word(input logic [31:0] w);
    fifo_mem[fifo_wr[7:0]] = w;
    fifo_wr++;
  endtask

  task automatic load4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    fifo_wr = fifo_rd;
    load_word(a); load_word(b); load_word(c); load_word(d);
  endtask

  // Runs one batch from IDLE to completion; drops host_open once batch_count moves.
  task automatic run_batch(input bit toggle, input int stall_at, output bit done,
                           output int recv_cyc, output bit exec_ok, output bit stall_ok);
    int unsigned p0, c0;
    int stall_rem;
    bit seen4, wren_seen;
    logic [15:0] bc0;
    p0 = fifo_rd; c0 = cap_n; bc0 = batch_count;
    stall_rem = 5; done = 0; recv_cyc = 0; exec_ok = 0; seen4 = 0; wren_seen = 0;
    host_open = 1'b1;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(posedge clk); #1;
      if (state == ST_RECV) recv_cyc++;
      if (!seen4 && (fifo_rd - p0) == 4) begin
        seen4 = 1;
        exec_ok = (state == ST_EXEC);
        in_snap = krn_in_data;
      end
      if (toggle) hold_empty = ~hold_empty;
      if (stall_at >= 0 && state == ST_SEND && (cap_n - c0) == stall_at && stall_rem > 0) begin
        send_full = 1'b1;
        #1;
        if (send_wren) wren_seen = 1;
        stall_rem--;
      end else begin
        send_full = 1'b0;
      end
      if (batch_count != bc0) begin
        done = 1;
        host_open = 1'b0;
      end
    end
    hold_empty = 1'b0;
    send_full = 1'b0;
    stall_ok = (stall_at < 0) || (stall_rem == 0 && !wren_seen);
  endtask

  task automatic test_reset;
    rst = 1'b1; host_open = 1'b0; send_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %b expected %b", state, ST_IDLE); end
    checks++; if (recv_rden !== 1'b0 || send_wren !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rden=%b wren=%b expected 0 0", recv_rden, send_wren); end
    checks++; if (krn_in_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h expected 00", krn_in_valid); end
    checks++; if (krn_in_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", krn_in_data); end
    checks++; if (batch_count !== 16'd0 || timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_counts: got bc=%0d to=%b expected 0 0", batch_count, timeout_flag); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL idle_closed: got %b expected %b", state, ST_IDLE); end
  endtask

  task automatic test_basic;
    logic [31:0] exp [4] = '{32'h00030002, 32'h00050004, 32'h00070006, 32'h00090008};
    int unsigned c0;
    bit done, exec_ok, stall_ok;
    int rc;
    load4(32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007);
    c0 = cap_n;
    run_batch(0, -1, done, rc, exec_ok, stall_ok);
    checks++; if (!done) begin errors++; $display("FAIL basic_done: batch did not complete in budget"); end
    checks++; if (rc != 4) begin errors++; $display("FAIL basic_recv_cycles: got %0d expected 4", rc); end
    checks++; if (!exec_ok) begin errors++; $display("FAIL basic_exec_entry: got 0 expected 1"); end
    checks++; if (in_snap !== 128'h00080007_00060005_00040003_00020001) begin errors++; $display("FAIL basic_krn_in: got %h expected 00080007000600050004000300020001", in_snap); end
    checks++; if (cap_n - c0 != 4) begin errors++; $display("FAIL basic_nwords: got %0d expected 4", cap_n - c0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_mem[c0 + i] !== exp[i]) begin errors++; $display("FAIL basic_word%0d: got %h expected %h", i, cap_mem[c0 + i], exp[i]); end
    end
    checks++; if (batch_count !== 16'd1) begin errors++; $display("FAIL basic_batch: got %0d expected 1", batch_count); end
    checks++; if (state !== ST_IDLE || krn_in_valid !== 8'h00) begin errors++; $display("FAIL basic_end: got st=%b v=%h expected 00001 00", state, krn_in_valid); end
  endtask

  task automatic test_recv_gaps;
    logic [31:0] exp [4] = '{32'h00130012, 32'h00150014, 32'h00170016, 32'h00190018};
    int unsigned c0, p0;
    bit done, exec_ok, stall_ok;
    int rc;
    load4(32'h00120011, 32'h00140013, 32'h00160015, 32'h00180017);
    load_word(32'hDEADBEEF); load_word(32'hDEADBEEF);
    c0 = cap_n; p0 = fifo_rd;
    run_batch(1, -1, done, rc, exec_ok, stall_ok);
    checks++; if (!done) begin errors++; $display("FAIL gaps_done: batch did not complete in budget"); end
    checks++; if (fifo_rd - p0 != 4) begin errors++; $display("FAIL gaps_pops: got %0d expected 4", fifo_rd - p0); end
    checks++; if (!exec_ok) begin errors++; $display("FAIL gaps_exec_entry: got 0 expected 1"); end
    checks++; if (in_snap !== 128'h00180017_00160015_00140013_00120011) begin errors++; $display("FAIL gaps_krn_in: got %h expected 00180017001600150014001300120011", in_snap); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_mem[c0 + i] !== exp[i]) begin errors++; $display("FAIL gaps_word%0d: got %h expected %h", i, cap_mem[c0 + i], exp[i]); end
    end
    checks++; if (batch_count !== 16'd2) begin errors++; $display("FAIL gaps_batch: got %0d expected 2", batch_count); end
  endtask

  task automatic test_send_stall;
    logic [31:0] exp [4] = '{32'h00230022, 32'h00250024, 32'h00270026, 32'h00290028};
    int unsigned c0;
    bit done, exec_ok, stall_ok;
    int rc;
    load4(32'h00220021, 32'h00240023, 32'h00260025, 32'h00280027);
    c0 = cap_n;
    run_batch(0, 2, done, rc, exec_ok, stall_ok);
    checks++; if (!done) begin errors++; $display("FAIL stall_done: batch did not complete in budget"); end
    checks++; if (!stall_ok) begin errors++; $display("FAIL stall_wren: got write during full expected none"); end
    checks++; if (cap_n - c0 != 4) begin errors++; $display("FAIL stall_nwords: got %0d expected 4", cap_n - c0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_mem[c0 + i] !== exp[i]) begin errors++; $display("FAIL stall_word%0d: got %h expected %h", i, cap_mem[c0 + i], exp[i]); end
    end
    checks++; if (batch_count !== 16'd3) begin errors++; $display("FAIL stall_batch: got %0d expected 3", batch_count); end
  endtask

  task automatic test_timeout;
    int unsigned c0, p0;
    int exec_cyc;
    bit hit;
    load4(32'h00320031, 32'h00340033, 32'h00360035, 32'h00380037);
    load_word(32'hCAFEF00D); load_word(32'hCAFEF00D);
    kblock = 1'b1;
    c0 = cap_n; exec_cyc = 0; hit = 0;
    host_open = 1'b1;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(posedge clk); #1;
      if (state == ST_EXEC) exec_cyc++;
      if (state == ST_ERR) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL timeout_err: state %b, ERR not reached in budget", state); end
    checks++; if (exec_cyc != 21) begin errors++; $display("FAIL timeout_cycles: got %0d expected 21", exec_cyc); end
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", timeout_flag); end
    p0 = fifo_rd;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state !== ST_ERR || recv_rden !== 1'b0 || send_wren !== 1'b0 || fifo_rd != p0) begin errors++; $display("FAIL timeout_hold: got st=%b rden=%b wren=%b pops=%0d expected 10000 0 0 0", state, recv_rden, send_wren, fifo_rd - p0); end
    checks++; if (cap_n != c0) begin errors++; $display("FAIL timeout_nwords: got %0d expected 0", cap_n - c0); end
    host_open = 1'b0;
    @(posedge clk); #1;
    checks++; if (state !== ST_IDLE || timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_exit: got st=%b to=%b expected 00001 1", state, timeout_flag); end
    checks++; if (batch_count !== 16'd3) begin errors++; $display("FAIL timeout_batch: got %0d expected 3", batch_count); end
    kblock = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_host_drop;
    logic [31:0] exp [4] = '{32'h00430042, 32'h00450044, 32'h00470046, 32'h00490048};
    int unsigned c0, p0;
    bit done, exec_ok, stall_ok, got2;
    int rc;
    fifo_wr = fifo_rd;
    load_word(32'h00AA00A9); load_word(32'h00AC00AB);
    p0 = fifo_rd; got2 = 0;
    host_open = 1'b1;
    for (int cyc = 0; cyc < 50 && !got2; cyc++) begin
      @(posedge clk); #1;
      if (fifo_rd - p0 == 2) got2 = 1;
    end
    checks++; if (!got2 || krn_in_valid !== 8'h0F) begin errors++; $display("FAIL drop_partial: got pops=%0d v=%h expected 2 0f", fifo_rd - p0, krn_in_valid); end
    host_open = 1'b0;
    @(posedge clk); #1;
    checks++; if (state !== ST_IDLE || krn_in_valid !== 8'h00) begin errors++; $display("FAIL drop_idle: got st=%b v=%h expected 00001 00", state, krn_in_valid); end
    checks++; if (batch_count !== 16'd3) begin errors++; $display("FAIL drop_batch: got %0d expected 3", batch_count); end
    load4(32'h00420041, 32'h00440043, 32'h00460045, 32'h00480047);
    c0 = cap_n;
    run_batch(0, -1, done, rc, exec_ok, stall_ok);
    checks++; if (!done || cap_n - c0 != 4) begin errors++; $display("FAIL drop_next: got done=%b nwords=%0d expected 1 4", done, cap_n - c0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_mem[c0 + i] !== exp[i]) begin errors++; $display("FAIL drop_word%0d: got %h expected %h", i, cap_mem[c0 + i], exp[i]); end
    end
    checks++; if (batch_count !== 16'd4) begin errors++; $display("FAIL drop_next_batch: got %0d expected 4", batch_count); end
  endtask

  task automatic test_rst_send;
    int unsigned c0;
    bit got1;
    load4(32'h00520051, 32'h00540053, 32'h00560055, 32'h00580057);
    c0 = cap_n; got1 = 0;
    host_open = 1'b1;
    for (int cyc = 0; cyc < 100 && !got1; cyc++) begin
      @(posedge clk); #1;
      if (cap_n - c0 == 1) got1 = 1;
    end
    checks++; if (!got1 || state !== ST_SEND) begin errors++; $display("FAIL rst_reach_send: got st=%b words=%0d expected 01000 1", state, cap_n - c0); end
    rst = 1'b1;
    #1;
    checks++; if (state !== ST_IDLE || send_wren !== 1'b0 || recv_rden !== 1'b0) begin errors++; $display("FAIL rst_async: got st=%b wren=%b rden=%b expected 00001 0 0", state, send_wren, recv_rden); end
    checks++; if (krn_in_valid !== 8'h00 || krn_in_data !== '0) begin errors++; $display("FAIL rst_krn: got v=%h d=%h expected 00 0", krn_in_valid, krn_in_data); end
    checks++; if (batch_count !== 16'd0 || timeout_flag !== 1'b0) begin errors++; $display("FAIL rst_counts: got bc=%0d to=%b expected 0 0", batch_count, timeout_flag); end
    host_open = 1'b0;
    repeat (2) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (cap_n - c0 != 1) begin errors++; $display("FAIL rst_no_partial: got %0d words expected 1", cap_n - c0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    host_open = 1'b0;
    send_full = 1'b0;
    test_reset;
    test_basic;
    test_recv_gaps;
    test_send_stall;
    test_timeout;
    test_host_drop;
    test_rst_send;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
